// File: rtl/seg7_hex_display.sv
// Multiplexed 8-digit 7-segment driver showing pc or inst in hex.
// Snapshots the selected value once per scan frame so digits never tear.
module seg7_hex_display #(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  input  logic        sel,
  input  logic        freeze,
  input  logic        blank_lz,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  localparam int unsigned       PCNT_W   = $clog2(SCAN_DIV);
  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(SCAN_DIV - 1);
  localparam logic [7:0]        OFF      = ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [PCNT_W-1:0] pcnt;
  logic [2:0]        idx;
  logic [31:0]       val_q;
  logic              load_pending;

  logic              tick_c;
  logic              frame_end_c;
  logic              load_c;
  logic [3:0]        nibble_c;
  logic [31:0]       upper_c;
  logic              blank_c;
  logic              dp_c;
  logic [6:0]        glyph_c;
  logic [7:0]        an_c;
  logic [7:0]        seg_c;

  // Scan timing and snapshot-load qualification
  always_comb begin
    tick_c      = (pcnt == PCNT_MAX);
    frame_end_c = tick_c && (idx == 3'd7);
    load_c      = (load_pending || frame_end_c) && !freeze;
  end

  // Prescaler, digit index and snapshot; freeze also holds a pending initial load
  always_ff @(posedge clk_in) begin
    if (reset) begin
      pcnt         <= '0;
      idx          <= '0;
      val_q        <= '0;
      load_pending <= 1'b1;
    end else begin
      pcnt <= tick_c ? '0 : pcnt + PCNT_W'(1);
      if (tick_c) begin
        idx <= idx + 3'd1;
      end
      if (load_c) begin
        val_q        <= sel ? inst : pc;
        load_pending <= 1'b0;
      end
    end
  end

  // Digit decode in active-high form; polarity applied at the output register
  always_comb begin
    nibble_c = val_q[{idx, 2'b00} +: 4];
    upper_c  = val_q >> {idx, 2'b00};
    blank_c  = blank_lz && (idx != 3'd0) && (upper_c == 32'd0);
    dp_c     = (idx == 3'd4) && !blank_c;
    glyph_c  = 7'h00;
    case (nibble_c)
      4'h0: glyph_c = 7'h3F;
      4'h1: glyph_c = 7'h06;
      4'h2: glyph_c = 7'h5B;
      4'h3: glyph_c = 7'h4F;
      4'h4: glyph_c = 7'h66;
      4'h5: glyph_c = 7'h6D;
      4'h6: glyph_c = 7'h7D;
      4'h7: glyph_c = 7'h07;
      4'h8: glyph_c = 7'h7F;
      4'h9: glyph_c = 7'h6F;
      4'hA: glyph_c = 7'h77;
      4'hB: glyph_c = 7'h7C;
      4'hC: glyph_c = 7'h39;
      4'hD: glyph_c = 7'h5E;
      4'hE: glyph_c = 7'h79;
      4'hF: glyph_c = 7'h71;
      default: glyph_c = 7'h00;
    endcase
    an_c  = blank_c ? 8'h00 : (8'h01 << idx);
    seg_c = blank_c ? 8'h00 : {dp_c, glyph_c};
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      an  <= OFF;
      seg <= OFF;
    end else begin
      an  <= an_c ^ OFF;
      seg <= seg_c ^ OFF;
    end
  end

endmodule

// File: tb/tb_seg7_hex_display.sv
// Directed, table-driven bench for seg7_hex_display (SCAN_DIV=4),
// with an active-low and an active-high instance.
module tb_seg7_hex_display;

  localparam int unsigned SD = 4;
  localparam logic [63:0] AN_ALL = 64'h7FBF_DFEF_F7FB_FDFE;

  logic        clk_in = 1'b0;
  logic        reset, reset_b;
  logic [31:0] pc, pc_b, inst;
  logic        sel, freeze, freeze_b, blank_lz;
  logic [7:0]  an, seg, an_b, seg_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic        sel;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        blank;
    logic [63:0] an_e;
    logic [63:0] seg_e;
  } vec_t;

  vec_t vecs[7];

  seg7_hex_display #(.SCAN_DIV(SD), .ACTIVE_LOW(1'b1)) dut_lo (
    .clk_in(clk_in), .reset(reset), .pc(pc), .inst(inst), .sel(sel),
    .freeze(freeze), .blank_lz(blank_lz), .an(an), .seg(seg)
  );

  seg7_hex_display #(.SCAN_DIV(SD), .ACTIVE_LOW(1'b0)) dut_hi (
    .clk_in(clk_in), .reset(reset_b), .pc(pc_b), .inst(inst), .sel(sel),
    .freeze(freeze_b), .blank_lz(blank_lz), .an(an_b), .seg(seg_b)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
    cyc++;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Check digits d_lo..d_hi, each for SD cycles, on one instance
  task automatic check_digits(input bit which, input int d_lo, input int d_hi,
                              input logic [63:0] an_e, input logic [63:0] seg_e,
                              input string name);
    for (int d = d_lo; d <= d_hi; d++) begin
      for (int c = 0; c < int'(SD); c++) begin
        step();
        chk($sformatf("%s an d%0d", name, d), which ? an_b : an, an_e[8*d +: 8]);
        chk($sformatf("%s seg d%0d", name, d), which ? seg_b : seg, seg_e[8*d +: 8]);
      end
    end
  endtask

  task automatic sync_frame();
    while ((cyc % (8 * SD)) != 0) step();
  endtask

  task automatic flush_frame();
    for (int i = 0; i < int'(8 * SD); i++) step();
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h0, 32'h0123ABCD, 1'b0, AN_ALL, 64'hC0F9_A430_8883_C6A1};
    vecs[1] = '{1'b0, 32'h00400000, 32'h0, 1'b1, 64'hFFFF_DFEF_F7FB_FDFE, 64'hFFFF_9940_C0C0_C0C0};
    vecs[2] = '{1'b0, 32'h89ABCDEF, 32'h0, 1'b1, AN_ALL, 64'h8090_8803_C6A1_868E};
    vecs[3] = '{1'b0, 32'h00000000, 32'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFC0};
    vecs[4] = '{1'b0, 32'h00000005, 32'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FF92};
    vecs[5] = '{1'b0, 32'h0000F000, 32'h0, 1'b1, 64'hFFFF_FFFF_F7FB_FDFE, 64'hFFFF_FFFF_8EC0_C0C0};
    vecs[6] = '{1'b1, 32'h0, 32'h76543210, 1'b0, AN_ALL, 64'hF882_9219_B0A4_F9C0};

    reset = 1'b1; reset_b = 1'b1;
    sel = 1'b0; pc = 32'h00400000; pc_b = 32'h0; inst = 32'h0;
    freeze = 1'b0; freeze_b = 1'b0; blank_lz = 1'b0;

    // Reset release
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst an", an, 8'hFF);
      chk("rst seg", seg, 8'hFF);
      chk("rst an_hi", an_b, 8'h00);
      chk("rst seg_hi", seg_b, 8'h00);
    end
    reset = 1'b0;
    cyc = 0;
    for (int i = 0; i < int'(SD); i++) begin
      step();
      chk("start an", an, 8'hFE);
      chk("start seg", seg, 8'hC0);
    end
    step();
    chk("start an d1", an, 8'hFD);
    chk("start seg d1", seg, 8'hC0);
    sync_frame();

    // Table: apply at frame start, let one frame_end load it, check the next frame
    for (int i = 0; i < 7; i++) begin
      sel = vecs[i].sel; pc = vecs[i].pc; inst = vecs[i].inst; blank_lz = vecs[i].blank;
      flush_frame();
      check_digits(1'b0, 0, 7, vecs[i].an_e, vecs[i].seg_e, $sformatf("vec%0d", i));
    end

    // Mid-frame sel switch is invisible until the next frame
    sel = 1'b0; pc = 32'h89ABCDEF; inst = 32'h76543210; blank_lz = 1'b0;
    flush_frame();
    check_digits(1'b0, 0, 2, AN_ALL, vecs[2].seg_e, "mid pre");
    sel = 1'b1;
    check_digits(1'b0, 3, 7, AN_ALL, vecs[2].seg_e, "mid hold");
    check_digits(1'b0, 0, 7, AN_ALL, vecs[6].seg_e, "mid new");

    // Freeze holds the snapshot; release loads at the following frame_end
    freeze = 1'b1; inst = 32'hDEADBEEF;
    for (int f = 0; f < 3; f++) check_digits(1'b0, 0, 7, AN_ALL, vecs[6].seg_e, $sformatf("frz%0d", f));
    freeze = 1'b0;
    check_digits(1'b0, 0, 7, AN_ALL, vecs[6].seg_e, "unfrz old");
    check_digits(1'b0, 0, 7, AN_ALL, 64'hA186_8821_8386_868E, "unfrz new");

    // Reset mid-frame at idx=5; active-high instance held frozen out of reset
    for (int i = 0; i < 22; i++) step();
    reset = 1'b1; reset_b = 1'b1;
    sel = 1'b0; pc = 32'h00400000; pc_b = 32'h00000012; freeze_b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("mrst an", an, 8'hFF);
      chk("mrst seg", seg, 8'hFF);
      chk("mrst an_hi", an_b, 8'h00);
      chk("mrst seg_hi", seg_b, 8'h00);
    end
    reset = 1'b0; reset_b = 1'b0;
    cyc = 0;
    check_digits(1'b0, 0, 7, AN_ALL, 64'hC0C0_9940_C0C0_C0C0, "after mrst");
    check_digits(1'b1, 0, 7, 64'h8040_2010_0804_0201, 64'h3F3F_3FBF_3F3F_3F3F, "hi frozen");
    freeze_b = 1'b0;
    step();
    chk("hi load an", an_b, 8'h01);
    chk("hi load seg", seg_b, 8'h3F);
    step();
    chk("hi loaded an", an_b, 8'h01);
    chk("hi loaded seg", seg_b, 8'h5B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
